// File: rtl/mips_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the instruction-fetch
// and data ports of a MIPS core; one transfer in flight, with a bounded wait for mem_ack.
module mips_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;
  localparam int CW = 8;

  state_t                state_q, state_d;
  logic                  last_d_q, last_d_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  if_ack_q, if_ack_d;
  logic                  d_ack_q, d_ack_d;
  logic                  bus_err_q, bus_err_d;
  logic                  grant_if;
  logic                  expired;

  // last_d_q set means data was granted last, so IF wins the next tie
  assign grant_if = if_req && (!d_req || last_d_q);
  assign expired  = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = if_ack_q;
    d_ack_d     = d_ack_q;
    bus_err_d   = bus_err_q;
    unique case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d     = BUSY_IF;
          last_d_d    = 1'b0;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end else if (d_req) begin
          state_d     = BUSY_D;
          last_d_d    = 1'b1;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end
      end
      BUSY_IF, BUSY_D: begin
        // mem_ack takes priority over an expiring wait counter
        if (mem_ack || expired) begin
          state_d     = RESP;
          bus_err_d   = !mem_ack;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          if (state_q == BUSY_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ack ? mem_rdata : '0;
          end else begin
            d_ack_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_ack ? mem_rdata : '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d   = IDLE;
        if_ack_d  = 1'b0;
        d_ack_d   = 1'b0;
        bus_err_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b1;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: transaction-level reference model
// (grant order, expected cycle of ack, rdata contents) driven by directed and random traffic.
module tb_mips_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_ack, d_req, d_we, d_ack;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic          mem_req, mem_we, mem_ack, bus_err;

  int total = 0;
  int bad   = 0;

  // reference model state: who won last, and what each port's rdata should hold
  bit            last_d_m;
  logic [DW-1:0] rd_if_m, rd_d_m;

  mips_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    last_d_m = 1'b1;
    rd_if_m  = '0;
    rd_d_m   = '0;
  endfunction

  // One full transfer, entered and left at a negedge in IDLE.
  // lat = index of the BUSY cycle that carries mem_ack; lat >= TO means no ack.
  task automatic txn(input bit rq_if, input bit rq_d, input logic [AW-1:0] a_if,
                     input bit we, input logic [AW-1:0] a_d, input logic [DW-1:0] wd,
                     input int lat, input logic [DW-1:0] rv, input bit stray);
    bit            g_if, timed_out, done;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    bit            e_we;
    int            i;
    total++; if ({if_ack, d_ack, bus_err, mem_req} !== 4'b0) begin bad++;
      $display("[TB] FAIL idle_outputs: got %b want 0000", {if_ack, d_ack, bus_err, mem_req}); end
    if_req = rq_if; d_req = rq_d; if_addr = a_if; d_we = we; d_addr = a_d; d_wdata = wd;
    mem_ack = stray; mem_rdata = DW'($urandom);
    g_if     = rq_if && (!rq_d || last_d_m);
    last_d_m = !g_if;
    e_addr   = g_if ? a_if : a_d;
    e_we     = g_if ? 1'b0 : we;
    e_wd     = g_if ? '0 : wd;
    timed_out = 1'b0; done = 1'b0; i = 0;
    while (!done) begin
      @(negedge clk);
      total++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, e_we, e_addr, e_wd}) begin bad++;
        $display("[TB] FAIL busy_mem_bus cyc%0d: got req=%b we=%b a=%h wd=%h want req=1 we=%b a=%h wd=%h",
                 i, mem_req, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wd); end
      total++; if ({if_ack, d_ack} !== 2'b00) begin bad++;
        $display("[TB] FAIL busy_acks cyc%0d: got %b want 00", i, {if_ack, d_ack}); end
      if_addr = AW'($urandom); d_addr = AW'($urandom); d_wdata = DW'($urandom); d_we = 1'($urandom);
      if (i == lat) begin
        mem_ack = 1'b1; mem_rdata = rv; done = 1'b1;
      end else begin
        mem_ack = 1'b0; mem_rdata = DW'($urandom);
        if (i == TO - 1) begin timed_out = 1'b1; done = 1'b1; end
      end
      i++;
    end
    if (g_if) rd_if_m = timed_out ? '0 : rv;
    else if (!we) rd_d_m = timed_out ? '0 : rv;
    @(negedge clk);
    total++; if ({if_ack, d_ack, bus_err} !== {g_if, !g_if, timed_out}) begin bad++;
      $display("[TB] FAIL resp_ack_err: got if_ack=%b d_ack=%b err=%b want %b %b %b",
               if_ack, d_ack, bus_err, g_if, !g_if, timed_out); end
    total++; if ({if_rdata, d_rdata} !== {rd_if_m, rd_d_m}) begin bad++;
      $display("[TB] FAIL resp_rdata: got if=%h d=%h want if=%h d=%h", if_rdata, d_rdata, rd_if_m, rd_d_m); end
    total++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin bad++;
      $display("[TB] FAIL resp_mem_idle: got req=%b we=%b a=%h wd=%h want all 0",
               mem_req, mem_we, mem_addr, mem_wdata); end
    if_req = 1'b0; d_req = 1'b0; mem_ack = stray; mem_rdata = DW'($urandom);
    @(negedge clk);
    mem_ack = 1'b0;
    total++; if ({if_ack, d_ack, bus_err, if_rdata, d_rdata} !== {3'b000, rd_if_m, rd_d_m}) begin bad++;
      $display("[TB] FAIL post_resp_idle: got acks=%b%b err=%b if=%h d=%h want 000 if=%h d=%h",
               if_ack, d_ack, bus_err, if_rdata, d_rdata, rd_if_m, rd_d_m); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0; if_addr = '0; d_addr = '0; d_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    model_reset();
    #3;
    total++; if ({if_ack, d_ack, bus_err, mem_req, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin bad++;
      $display("[TB] FAIL reset_outputs: got acks=%b%b err=%b req=%b we=%b a=%h wd=%h if=%h d=%h want all 0",
               if_ack, d_ack, bus_err, mem_req, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_fetch();
    txn(1'b1, 1'b0, 16'h0010, 1'b0, 16'h0000, 16'h0000, 0, 16'h1234, 1'b0);
  endtask

  task automatic test_contention();
    for (int k = 0; k < 4; k++)
      txn(1'b1, 1'b1, 16'h0100 + AW'(k), 1'b0, 16'h0200 + AW'(k), 16'h0, 0, 16'hA000 + DW'(k), 1'b0);
  endtask

  task automatic test_write();
    txn(1'b0, 1'b1, 16'h0000, 1'b1, 16'h00FE, 16'hBEEF, 2, 16'h5555, 1'b0);
  endtask

  task automatic test_timeout();
    txn(1'b0, 1'b1, 16'h0, 1'b0, 16'h0040, 16'h0, 1, 16'h7E57, 1'b0);
    txn(1'b0, 1'b1, 16'h0, 1'b0, 16'h0042, 16'h0, TO + 4, 16'hFFFF, 1'b0);
    txn(1'b0, 1'b1, 16'h0, 1'b0, 16'h0044, 16'h0, TO - 1, 16'h4321, 1'b0);
    txn(1'b1, 1'b0, 16'h0046, 1'b0, 16'h0, 16'h0, TO, 16'hFFFF, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    if_req = 1'b1; if_addr = 16'h0300;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({mem_req, if_ack, d_ack, mem_addr, if_rdata, d_rdata} !== '0) begin bad++;
      $display("[TB] FAIL reset_mid_op: got req=%b acks=%b%b a=%h if=%h d=%h want all 0",
               mem_req, if_ack, d_ack, mem_addr, if_rdata, d_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    txn(1'b1, 1'b0, 16'h0300, 1'b0, 16'h0, 16'h0, 0, 16'hCAFE, 1'b0);
  endtask

  task automatic test_stray();
    for (int k = 0; k < 3; k++) begin
      mem_ack = 1'b1; mem_rdata = DW'($urandom);
      @(negedge clk);
      total++; if ({if_ack, d_ack, mem_req, if_rdata, d_rdata} !== {3'b000, rd_if_m, rd_d_m}) begin bad++;
        $display("[TB] FAIL stray_ack: got acks=%b%b req=%b if=%h d=%h want 000 if=%h d=%h",
                 if_ack, d_ack, mem_req, if_rdata, d_rdata, rd_if_m, rd_d_m); end
    end
    mem_ack = 1'b0;
    txn(1'b1, 1'b1, 16'h0500, 1'b0, 16'h0600, 16'h0, 1, 16'h9876, 1'b1);
  endtask

  task automatic test_random();
    int sel, r, lat;
    for (int k = 0; k < 30; k++) begin
      sel = $urandom_range(0, 2);
      r   = $urandom_range(0, 9);
      lat = (r < 7) ? $urandom_range(0, 3) : ((r == 7) ? TO - 1 : TO + 3);
      txn(sel != 1, sel != 0, AW'($urandom), 1'($urandom), AW'($urandom), DW'($urandom),
          lat, DW'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_reset();
    test_contention();
    test_write();
    test_timeout();
    test_reset_mid_op();
    test_stray();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, memory data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, max BUSY cycles awaiting mem_ack (legal range 2..255).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports if_req input 1, if_addr input ADDR_WIDTH, if_rdata output DATA_WIDTH, if_ack output 1: instruction-fetch requester (read-only).
REQ-007 SHALL have ports d_req input 1, d_we input 1, d_addr input ADDR_WIDTH, d_wdata input DATA_WIDTH, d_rdata output DATA_WIDTH, d_ack output 1: data requester.
REQ-008 SHALL have ports mem_req output 1, mem_we output 1, mem_addr output ADDR_WIDTH, mem_wdata output DATA_WIDTH, mem_rdata input DATA_WIDTH, mem_ack input 1: shared single-port memory.
REQ-009 SHALL have port bus_err output 1, pulses with an ack when that transfer timed out.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY_IF, BUSY_D, RESP; exactly one transfer outstanding at a time.
REQ-011 IDLE: if_req only -> BUSY_IF; d_req only -> BUSY_D; both -> requester not granted last (round-robin via last_grant register); neither -> stay IDLE.
REQ-012 On entering BUSY_x, SHALL register requester address/data/we into mem_addr, mem_wdata, mem_we (if path: mem_we=0, mem_wdata=0) and assert mem_req.
REQ-013 mem_req, mem_we, mem_addr, mem_wdata SHALL be 0 in IDLE and RESP and stable throughout BUSY_x.
REQ-014 BUSY_x with mem_ack sampled high -> RESP; the granted port's rdata SHALL load mem_rdata on a read, hold its previous value on a write.
REQ-015 Wait counter SHALL clear on entering BUSY_x and increment each BUSY cycle without mem_ack; at count TIMEOUT-1 without mem_ack -> RESP with error flag set, rdata loaded with 0 on a read.
REQ-016 mem_ack and timeout in the same cycle: mem_ack wins, no error.
REQ-017 RESP lasts exactly one cycle: granted port's ack=1, bus_err=error flag; other port's ack=0; then -> IDLE, error flag cleared.
REQ-018 Requests sampled during RESP SHALL be ignored; a requester deasserts req (or presents a new request) at the edge where it samples ack high.
REQ-019 Minimum latency: req high in cycle 0 -> mem_req high cycle 1 -> (mem_ack in cycle 1) -> ack high cycle 2; sustained throughput one transfer per 3 cycles.
REQ-020 last_grant SHALL update on every transition into BUSY_x, including timed-out transfers.
REQ-021 Requester signals other than req are sampled only at the grant edge; changes while BUSY SHALL not affect the transfer.
REQ-022 mem_ack while not in BUSY_x SHALL be ignored.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, all outputs 0 (if_rdata, d_rdata, acks, bus_err, mem_*), counter 0, error flag 0, last_grant=D (first contended grant goes to IF).
REQ-024 Reset asserted mid-transfer SHALL abandon it without ack; after release, pending reqs are arbitrated afresh from IDLE.

Verification
REQ-025 Single fetch: if_req=1, if_addr=0x0010, memory acks in 1st BUSY cycle with 0x1234 -> mem_req cycle 1, if_ack=1 and if_rdata=0x1234 cycle 2, d_ack=0.
REQ-026 Contention after reset: if_req=d_req=1 continuously -> grants IF, D, IF, D; each ack 3 cycles apart; mem_addr alternates between if_addr and d_addr.
REQ-027 Data write: d_req=1, d_we=1, d_addr=0x00FE, d_wdata=0xBEEF, mem_ack after 3 cycles -> mem_we=1, mem_wdata=0xBEEF held 3 cycles, d_ack=1, d_rdata unchanged, bus_err=0.
REQ-028 Timeout: d_req read, mem_ack never asserted, TIMEOUT=15 -> mem_req high 15 cycles, then d_ack=1, bus_err=1, d_rdata=0x0000, next cycle IDLE; mem_ack exactly in 15th cycle -> no error.
REQ-029 Reset mid-op: rst_n low in 2nd BUSY_IF cycle -> mem_req=0 and if_ack=0 immediately; with if_req held, release -> new grant, ack 2 cycles after mem_ack-capable cycle.
REQ-030 Stray mem_ack in IDLE/RESP -> no ack, no rdata change.
